// File: rtl/mdu_alu_sequencer.sv
// RV32M multiply/divide sequencer driving a shared execute-stage ALU.
// Ports: clk/rst, start/kill/op/a/b request, busy/done/result status,
//        alu_op1/alu_op2/alu_ctrl to the ALU, alu_out/alu_c back from it.
// Optional: define MDU_EARLY_OUT_EN for latency-1 trivial mul/divu/remu.
module mdu_alu_sequencer #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             kill,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] alu_op1,
   output logic [WIDTH-1:0] alu_op2,
   output logic [3:0]       alu_ctrl,
   input  logic [WIDTH-1:0] alu_out,
   input  logic             alu_c
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_PREP  = 3'd1;
   localparam logic [2:0] S_ITER  = 3'd2;
   localparam logic [2:0] S_FIXUP = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;
   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b0001;
   localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   logic [2:0]       state_q, state_d;
   logic [2:0]       op_q, op_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic [WIDTH-1:0] opnd_q, opnd_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             neg_q, neg_d;
   logic [WIDTH-1:0] result_q, result_d;

   logic             spec_hit;
   logic [WIDTH-1:0] spec_val;
   logic             sgn_a, sgn_b;
   logic [WIDTH-1:0] abs_a, abs_b;
   logic [WIDTH-1:0] r_sh, sel;
   logic             carry, take;

   // Accept-time special cases resolved without iterating
   always_comb begin
      spec_hit = 1'b0;
      spec_val = '0;
      if (op[2] && b == '0) begin
         spec_hit = 1'b1;
         spec_val = op[1] ? a : '1;
      end else if ((op == 3'b100 || op == 3'b110) &&
                   a == MIN_NEG && b == '1) begin
         spec_hit = 1'b1;
         spec_val = op[1] ? '0 : a;
      end
`ifdef MDU_EARLY_OUT_EN
      else if (!op[2] && (a == '0 || b == '0)) begin
         spec_hit = 1'b1;
         spec_val = '0;
      end else if (op[2] && op[0] && a < b) begin
         spec_hit = 1'b1;
         spec_val = op[1] ? a : '0;
      end
`endif
   end

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      a_d      = a_q;
      b_d      = b_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      opnd_d   = opnd_q;
      cnt_d    = cnt_q;
      neg_d    = neg_q;
      result_d = result_q;
      alu_op1  = '0;
      alu_op2  = '0;
      alu_ctrl = ALU_ADD;
      sgn_a    = (op_q == 3'b001 || op_q == 3'b010 ||
                  op_q == 3'b100 || op_q == 3'b110) && a_q[WIDTH-1];
      sgn_b    = (op_q == 3'b001 || op_q == 3'b100 ||
                  op_q == 3'b110) && b_q[WIDTH-1];
      abs_a    = sgn_a ? -a_q : a_q;
      abs_b    = sgn_b ? -b_q : b_q;
      r_sh     = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
      carry    = 1'b0;
      take     = 1'b0;
      sel      = '0;
      unique case (state_q)
         S_IDLE: begin
            if (start && !kill) begin
               op_d = op;
               a_d  = a;
               b_d  = b;
               if (spec_hit) begin
                  result_d = spec_val;
                  state_d  = S_DONE;
               end else begin
                  state_d = S_PREP;
               end
            end
         end
         S_PREP: begin
            hi_d   = '0;
            lo_d   = op_q[2] ? abs_a : abs_b;
            opnd_d = op_q[2] ? abs_b : abs_a;
            // Remainder takes the dividend's sign only
            neg_d  = (op_q[2] && op_q[1]) ? sgn_a : (sgn_a ^ sgn_b);
            cnt_d  = '0;
            state_d = S_ITER;
         end
         S_ITER: begin
            if (!op_q[2]) begin
               // Adding zero when LO[0]=0 leaves HI and carry untouched
               alu_ctrl = ALU_ADD;
               alu_op1  = hi_q;
               alu_op2  = lo_q[0] ? opnd_q : '0;
               carry    = alu_out < hi_q;
               hi_d     = {carry, alu_out[WIDTH-1:1]};
               lo_d     = {alu_out[0], lo_q[WIDTH-1:1]};
            end else begin
               alu_ctrl = ALU_SUB;
               alu_op1  = r_sh;
               alu_op2  = opnd_q;
               take     = !alu_c || hi_q[WIDTH-1];
               hi_d     = take ? alu_out : r_sh;
               lo_d     = {lo_q[WIDTH-2:0], take};
            end
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH-1)) state_d = S_FIXUP;
         end
         S_FIXUP: begin
            if (op_q[2]) sel = op_q[1] ? hi_q : lo_q;
            else         sel = (op_q == 3'b000) ? lo_q : hi_q;
            result_d = sel;
            if (neg_q) begin
               if (!op_q[2]) begin
                  alu_ctrl = ALU_ADD;
                  alu_op1  = ~hi_q;
                  alu_op2  = {{(WIDTH-1){1'b0}}, lo_q == '0};
               end else begin
                  alu_ctrl = ALU_SUB;
                  alu_op1  = '0;
                  alu_op2  = op_q[1] ? hi_q : lo_q;
               end
               result_d = alu_out;
            end
            state_d = S_DONE;
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (kill && state_q != S_IDLE) begin
         state_d  = S_IDLE;
         result_d = result_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         op_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         opnd_q   <= '0;
         cnt_q    <= '0;
         neg_q    <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         a_q      <= a_d;
         b_q      <= b_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         opnd_q   <= opnd_d;
         cnt_q    <= cnt_d;
         neg_q    <= neg_d;
         result_q <= result_d;
      end
   end

   assign busy   = state_q != S_IDLE;
   assign done   = state_q == S_DONE;
   assign result = result_q;

endmodule
